package_extractor: RTL and testbench

- Downstream consumer of header_decoder's get_package flag. Sits on the same 16-bit word stream that feeds the six header buffers.
- Once a header is flagged, captures the fixed-length payload that follows and streams it out with first/last framing. Keeps a completed-package count.
- Aborts the package on a header collision inside the payload or on an input stall timeout. Both abort paths produce an error pulse.

---
 rtl/package_extractor.sv | 139 +++++++++++++
 tb/tb_package_extractor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/package_extractor.sv
// Captures the fixed-length payload that follows a flagged header and streams it
// out with first/last framing. A collision word or an input stall aborts the package.
module package_extractor #(
    parameter int unsigned PAYLOAD_WORDS  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic        get_package,
    output logic [15:0] pkg_data,
    output logic        pkg_valid,
    output logic        pkg_first,
    output logic        pkg_last,
    output logic        pkg_abort,
    output logic        err_collision,
    output logic        err_timeout,
    output logic [15:0] pkg_count,
    output logic        busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam logic [15:0] LAST_IDX    = 16'(PAYLOAD_WORDS - 1);
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state, state_next;
    logic [15:0] word_cnt, word_cnt_next;
    logic [15:0] stall_cnt, stall_cnt_next;
    logic [15:0] stall_cnt_inc;
    logic [15:0] pkg_data_next, pkg_count_next;
    logic        pkg_valid_next, pkg_first_next, pkg_last_next;
    logic        pkg_abort_next, err_collision_next, err_timeout_next;
    logic        accept, collision;

    // The word seen together with get_package in IDLE is already payload word 0.
    assign accept        = data_valid && ((state == CAPTURE) || get_package);
    assign collision     = (data_in[15:14] == 2'b11);
    assign stall_cnt_inc = stall_cnt + 16'd1;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_next         = state;
        word_cnt_next      = word_cnt;
        stall_cnt_next     = stall_cnt;
        pkg_data_next      = pkg_data;
        pkg_count_next     = pkg_count;
        pkg_valid_next     = 1'b0;
        pkg_first_next     = 1'b0;
        pkg_last_next      = 1'b0;
        pkg_abort_next     = 1'b0;
        err_collision_next = 1'b0;
        err_timeout_next   = 1'b0;

        case (state)
            IDLE: begin
                if (get_package) begin
                    state_next     = CAPTURE;
                    word_cnt_next  = '0;
                    stall_cnt_next = '0;
                end
            end
            CAPTURE: begin
                if (!data_valid) begin
                    if (stall_cnt_inc == STALL_LIMIT) begin
                        err_timeout_next = 1'b1;
                        pkg_abort_next   = 1'b1;
                        state_next       = IDLE;
                        word_cnt_next    = '0;
                        stall_cnt_next   = '0;
                    end else begin
                        stall_cnt_next = stall_cnt_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Accepting a word overrides the arm/stall decisions made above.
        if (accept) begin
            stall_cnt_next = '0;
            if (collision) begin
                err_collision_next = 1'b1;
                pkg_abort_next     = 1'b1;
                state_next         = IDLE;
                word_cnt_next      = '0;
            end else begin
                pkg_valid_next = 1'b1;
                pkg_data_next  = data_in;
                pkg_first_next = (word_cnt == '0);
                if (word_cnt == LAST_IDX) begin
                    pkg_last_next  = 1'b1;
                    pkg_count_next = pkg_count + 16'd1;
                    state_next     = IDLE;
                    word_cnt_next  = '0;
                end else begin
                    state_next    = CAPTURE;
                    word_cnt_next = word_cnt + 16'd1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            word_cnt      <= '0;
            stall_cnt     <= '0;
            pkg_data      <= '0;
            pkg_count     <= '0;
            pkg_valid     <= 1'b0;
            pkg_first     <= 1'b0;
            pkg_last      <= 1'b0;
            pkg_abort     <= 1'b0;
            err_collision <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            state         <= state_next;
            word_cnt      <= word_cnt_next;
            stall_cnt     <= stall_cnt_next;
            pkg_data      <= pkg_data_next;
            pkg_count     <= pkg_count_next;
            pkg_valid     <= pkg_valid_next;
            pkg_first     <= pkg_first_next;
            pkg_last      <= pkg_last_next;
            pkg_abort     <= pkg_abort_next;
            err_collision <= err_collision_next;
            err_timeout   <= err_timeout_next;
        end
    end

    assign busy = (state == CAPTURE);

endmodule

// File: tb/tb_package_extractor.sv
// Randomised and directed bench for package_extractor: two instances (32-word/8-cycle
// timeout and 1-word packages) are checked every cycle against a behavioural model.
module tb_package_extractor;

    localparam int P_A = 32;
    localparam int T_A = 8;
    localparam int P_B = 1;
    localparam int T_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, dv_a, gp_a;
    logic [15:0] din_a, data_a, count_a;
    logic        valid_a, first_a, last_a, abort_a, coll_a, to_a, busy_a;

    logic        rst_b, dv_b, gp_b;
    logic [15:0] din_b, data_b, count_b;
    logic        valid_b, first_b, last_b, abort_b, coll_b, to_b, busy_b;

    package_extractor #(.PAYLOAD_WORDS(P_A), .TIMEOUT_CYCLES(T_A)) dut_a (
        .clk(clk), .rst(rst_a), .data_in(din_a), .data_valid(dv_a), .get_package(gp_a),
        .pkg_data(data_a), .pkg_valid(valid_a), .pkg_first(first_a), .pkg_last(last_a),
        .pkg_abort(abort_a), .err_collision(coll_a), .err_timeout(to_a),
        .pkg_count(count_a), .busy(busy_a)
    );

    package_extractor #(.PAYLOAD_WORDS(P_B), .TIMEOUT_CYCLES(T_B)) dut_b (
        .clk(clk), .rst(rst_b), .data_in(din_b), .data_valid(dv_b), .get_package(gp_b),
        .pkg_data(data_b), .pkg_valid(valid_b), .pkg_first(first_b), .pkg_last(last_b),
        .pkg_abort(abort_b), .err_collision(coll_b), .err_timeout(to_b),
        .pkg_count(count_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model view of a package: are we inside one, which payload index comes next,
    // how long the input has been quiet, and how many packages have completed.
    typedef struct {
        bit active;
        int idx;
        int quiet;
        int done;
    } mdl_t;

    typedef struct {
        bit          valid, first, last, abort, coll, to, busy;
        logic [15:0] data;
        logic [15:0] count;
    } exp_t;

    task automatic model_step(inout mdl_t m, input int p, input int t, input logic r,
                              input logic dv, input logic gp, input logic [15:0] d,
                              output exp_t e);
        e.valid = 0; e.first = 0; e.last = 0; e.abort = 0; e.coll = 0; e.to = 0;
        e.data  = 16'h0;
        if (r) begin
            m.active = 0; m.idx = 0; m.quiet = 0; m.done = 0;
        end else if (dv && (m.active || gp)) begin
            m.quiet = 0;
            if (d[15:14] == 2'b11) begin
                e.coll = 1; e.abort = 1;
                m.active = 0; m.idx = 0;
            end else begin
                e.valid = 1; e.data = d;
                e.first = (m.idx == 0);
                e.last  = (m.idx == p - 1);
                if (e.last) begin
                    m.done = (m.done + 1) % 65536;
                    m.active = 0; m.idx = 0;
                end else begin
                    m.active = 1; m.idx++;
                end
            end
        end else if (m.active) begin
            m.quiet++;
            if (m.quiet == t) begin
                e.to = 1; e.abort = 1;
                m.active = 0; m.idx = 0; m.quiet = 0;
            end
        end else if (gp) begin
            m.active = 1; m.idx = 0; m.quiet = 0;
        end
        e.count = 16'(m.done);
        e.busy  = m.active;
    endtask

    function automatic logic [63:0] pack(logic [15:0] cnt, logic [15:0] d, logic v, logic f,
                                         logic l, logic ab, logic c, logic t, logic b);
        return {25'd0, cnt, (v ? d : 16'h0), v, f, l, ab, c, t, b};
    endfunction

    mdl_t m_a = '{0, 0, 0, 0};
    mdl_t m_b = '{0, 0, 0, 0};
    exp_t e_a, e_b;

    int          n_valid_a, n_coll_a, n_to_a, n_abort_a;
    logic [15:0] first_data_a, last_data_a;

    // Inputs change only on the falling edge, so they still hold the sampled values here.
    always @(posedge clk) begin
        #1;
        model_step(m_a, P_A, T_A, rst_a, dv_a, gp_a, din_a, e_a);
        check("A outputs",
              pack(count_a, data_a, valid_a, first_a, last_a, abort_a, coll_a, to_a, busy_a),
              pack(e_a.count, e_a.data, e_a.valid, e_a.first, e_a.last, e_a.abort, e_a.coll,
                   e_a.to, e_a.busy));
        model_step(m_b, P_B, T_B, rst_b, dv_b, gp_b, din_b, e_b);
        check("B outputs",
              pack(count_b, data_b, valid_b, first_b, last_b, abort_b, coll_b, to_b, busy_b),
              pack(e_b.count, e_b.data, e_b.valid, e_b.first, e_b.last, e_b.abort, e_b.coll,
                   e_b.to, e_b.busy));
        if (valid_a) n_valid_a++;
        if (coll_a)  n_coll_a++;
        if (to_a)    n_to_a++;
        if (abort_a) n_abort_a++;
        if (valid_a && first_a) first_data_a = data_a;
        if (valid_a && last_a)  last_data_a  = data_a;
    end

    task automatic clr_mon();
        n_valid_a = 0; n_coll_a = 0; n_to_a = 0; n_abort_a = 0;
        first_data_a = 16'hDEAD; last_data_a = 16'hDEAD;
    endtask

    task automatic drv_a(input logic r, input logic gp, input logic dv, input logic [15:0] d);
        rst_a = r; gp_a = gp; dv_a = dv; din_a = d;
        @(negedge clk);
    endtask

    task automatic drv_b(input logic r, input logic gp, input logic dv, input logic [15:0] d);
        rst_b = r; gp_b = gp; dv_b = dv; din_b = d;
        @(negedge clk);
    endtask

    // One package on A; optional 3-cycle gaps after every 4th word, optional collision word.
    task automatic send_pkg_a(input bit gaps, input int coll_at);
        for (int i = 0; i < P_A; i++) begin
            drv_a(0, 1, 1, (i == coll_at) ? 16'hC123 : 16'(i));
            if (i == coll_at) break;
            if (gaps && (i % 4 == 3) && (i != P_A - 1))
                for (int g = 0; g < 3; g++) drv_a(0, 1, 0, 16'h0);
        end
        drv_a(0, 0, 0, 16'h0);
        drv_a(0, 0, 0, 16'h0);
    endtask

    task automatic run_a();
        logic [15:0] w;
        int          dv_pct;
        drv_a(1, 0, 0, 16'h0);
        drv_a(1, 0, 0, 16'h0);
        check("reset pkg_count", 64'(count_a), 64'h0);
        check("reset busy", 64'(busy_a), 64'h0);
        check("reset pkg_data", 64'(data_a), 64'h0);
        check("reset pulses", 64'({valid_a, first_a, last_a, abort_a, coll_a, to_a}), 64'h0);

        clr_mon();
        send_pkg_a(0, -1);
        check("contig words", 64'(n_valid_a), 64'd32);
        check("contig first data", 64'(first_data_a), 64'h0000);
        check("contig last data", 64'(last_data_a), 64'h001F);
        check("contig pkg_count", 64'(count_a), 64'd1);
        check("contig busy", 64'(busy_a), 64'h0);

        clr_mon();
        send_pkg_a(1, -1);
        check("gaps words", 64'(n_valid_a), 64'd32);
        check("gaps errors", 64'(n_abort_a + n_coll_a + n_to_a), 64'd0);
        check("gaps pkg_count", 64'(count_a), 64'd2);

        clr_mon();
        send_pkg_a(0, 10);
        check("coll words", 64'(n_valid_a), 64'd10);
        check("coll pulses", 64'(n_coll_a), 64'd1);
        check("coll abort", 64'(n_abort_a), 64'd1);
        check("coll pkg_count", 64'(count_a), 64'd2);
        check("coll busy", 64'(busy_a), 64'h0);

        clr_mon();
        for (int i = 0; i < 6; i++) drv_a(0, 1, 1, 16'(i));
        for (int i = 0; i < T_A + 2; i++) drv_a(0, 0, 0, 16'h0);
        check("timeout words", 64'(n_valid_a), 64'd6);
        check("timeout pulses", 64'(n_to_a), 64'd1);
        check("timeout abort", 64'(n_abort_a), 64'd1);
        check("timeout busy", 64'(busy_a), 64'h0);

        clr_mon();
        for (int i = 0; i < 6; i++) drv_a(0, 1, 1, 16'(i));
        for (int i = 0; i < T_A - 1; i++) drv_a(0, 0, 0, 16'h0);
        for (int i = 6; i < P_A; i++) drv_a(0, 1, 1, 16'(i));
        drv_a(0, 0, 0, 16'h0);
        check("late word no timeout", 64'(n_to_a), 64'd0);
        check("late word pkg_count", 64'(count_a), 64'd3);

        for (int i = 0; i < 15; i++) drv_a(0, 1, 1, 16'(i));
        drv_a(1, 1, 1, 16'd15);
        check("midreset outputs",
              64'({count_a, data_a, valid_a, first_a, last_a, abort_a, coll_a, to_a, busy_a}),
              64'h0);
        drv_a(0, 0, 0, 16'h0);
        send_pkg_a(0, -1);
        check("after reset pkg_count", 64'(count_a), 64'd1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) dv_pct = (i % 600 == 0) ? 90 : ((i % 600 == 200) ? 50 : 10);
            w = 16'($urandom);
            if ($urandom_range(0, 31) != 0) w[15] = 1'b0;
            drv_a($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < dv_pct, w);
        end
        drv_a(0, 0, 0, 16'h0);
    endtask

    task automatic run_b();
        drv_b(1, 0, 0, 16'h0);
        drv_b(1, 0, 0, 16'h0);
        for (int i = 0; i < 65535; i++) drv_b(0, 1, 1, 16'($urandom) & 16'h3FFF);
        check("B count preload", 64'(count_b), 64'hFFFF);
        drv_b(0, 1, 1, 16'h1234);
        check("B count wrap", 64'(count_b), 64'h0000);
        drv_b(0, 0, 0, 16'h0);
    endtask

    initial begin
        rst_a = 1; gp_a = 0; dv_a = 0; din_a = 16'h0;
        rst_b = 1; gp_b = 0; dv_b = 0; din_b = 16'h0;
        clr_mon();
        @(negedge clk);
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
